// File: rtl/vga_term_writer.sv
// vga_term_writer: maps CPU ASCII to 6-bit display codes and writes them into 40x24 video RAM with cursor, wrap and scroll.
// Define TERM_CLEAR_EN to add the clr_screen port and the full-screen clear (CLRALL) state.
module vga_term_writer #(
   parameter int         COLS  = 40,
   parameter int         ROWS  = 24,
   parameter logic [5:0] BLANK = 6'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
`ifdef TERM_CLEAR_EN
   input  logic       clr_screen,
`endif
   output logic [9:0] vram_waddr,
   output logic       vram_wen,
   output logic [5:0] vram_din,
   output logic [4:0] top_line,
   output logic [5:0] cursor_col,
   output logic [4:0] cursor_row
);
   localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
   localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
   localparam logic [5:0] ROWS6     = 6'(ROWS);
   localparam logic [9:0] LAST_CELL = 10'(COLS * ROWS - 1);

`ifdef TERM_CLEAR_EN
   typedef enum logic [2:0] {IDLE, WRITE, NEWLINE, CLEAR, CLRALL} state_t;
`else
   typedef enum logic [2:0] {IDLE, WRITE, NEWLINE, CLEAR} state_t;
`endif

   state_t     state, state_n;
   logic [4:0] lv, lv_n, top_n;
   logic [5:0] col_n, code, code_n, mapped;
   logic [9:0] cnt, cnt_n, row_base;
   logic [5:0] row_sum;

   // physical row is the logical line offset by top_line, wrapped without a divider
   always_comb begin
      row_sum    = {1'b0, top_line} + {1'b0, lv};
      cursor_row = (row_sum >= ROWS6) ? 5'(row_sum - ROWS6) : row_sum[4:0];
      row_base   = ({5'd0, cursor_row} << 5) + ({5'd0, cursor_row} << 3);
      mapped     = (char_in[6:5] == 2'b11) ? char_in[5:0] - 6'h20 : char_in[5:0];
   end

   always_comb begin
      state_n    = state;
      lv_n       = lv;
      top_n      = top_line;
      col_n      = cursor_col;
      code_n     = code;
      cnt_n      = cnt;
      char_ready = 1'b0;
      vram_wen   = 1'b0;
      vram_waddr = '0;
      vram_din   = '0;
      case (state)
         IDLE: begin
            char_ready = 1'b1;
`ifdef TERM_CLEAR_EN
            char_ready = ~clr_screen;
            if (clr_screen) begin
               cnt_n   = '0;
               state_n = CLRALL;
            end else
`endif
            if (char_valid) begin
               if (char_in[6:5] != 2'b00) begin
                  code_n  = mapped;
                  state_n = WRITE;
               end else if (char_in == 7'h0D) state_n = NEWLINE;
            end
         end
         WRITE: begin
            vram_wen   = 1'b1;
            vram_waddr = row_base + {4'd0, cursor_col};
            vram_din   = code;
            col_n      = (cursor_col == LAST_COL) ? cursor_col : cursor_col + 6'd1;
            state_n    = (cursor_col == LAST_COL) ? NEWLINE : IDLE;
         end
         NEWLINE: begin
            col_n = '0;
            if (lv != LAST_ROW) begin
               lv_n    = lv + 5'd1;
               state_n = IDLE;
            end else begin
               top_n   = (top_line == LAST_ROW) ? 5'd0 : top_line + 5'd1;
               cnt_n   = '0;
               state_n = CLEAR;
            end
         end
         CLEAR: begin
            vram_wen   = 1'b1;
            vram_waddr = row_base + cnt;
            vram_din   = BLANK;
            cnt_n      = cnt + 10'd1;
            state_n    = (cnt[5:0] == LAST_COL) ? IDLE : CLEAR;
         end
`ifdef TERM_CLEAR_EN
         CLRALL: begin
            vram_wen   = 1'b1;
            vram_waddr = cnt;
            vram_din   = BLANK;
            cnt_n      = cnt + 10'd1;
            if (cnt == LAST_CELL) begin
               top_n   = '0;
               lv_n    = '0;
               col_n   = '0;
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lv         <= '0;
         top_line   <= '0;
         cursor_col <= '0;
         code       <= '0;
         cnt        <= '0;
      end else begin
         state      <= state_n;
         lv         <= lv_n;
         top_line   <= top_n;
         cursor_col <= col_n;
         code       <= code_n;
         cnt        <= cnt_n;
      end
   end
endmodule
